// File: rtl/rob_pkg.sv
// Shared types for the out-of-order read responder: ID width, slot FSM states.
package rob_pkg;
    localparam int ID_WIDTH = 4;
    localparam int NUM_IDS  = 16;
    localparam int TIMER_W  = 8;

    typedef logic [ID_WIDTH-1:0] id_t;
    typedef enum logic [1:0] {IDLE, WAIT, READY, ISSUED} slot_state_t;
endpackage

// File: rtl/ooo_slot.sv
// One per-ID slot: latency timer, captured sequence number and lifecycle FSM.
module ooo_slot
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [TIMER_W-1:0]    i_lat,
    input  logic [DATA_WIDTH-1:0] i_seq,
    input  logic                  i_grant,
    input  logic                  i_retire,
    output slot_state_t           o_state,
    output logic [DATA_WIDTH-1:0] o_seq
);
    slot_state_t           r_state, w_state_nxt;
    logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic [DATA_WIDTH-1:0] r_seq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (i_load && r_state == IDLE)
                r_seq <= i_seq;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            IDLE: if (i_load) begin
                w_state_nxt = WAIT;
                w_timer_nxt = i_lat;
            end
            // Timer holds L-1 on entry, so READY is reached L edges after accept.
            WAIT: if (r_timer == '0) w_state_nxt = READY;
                  else               w_timer_nxt = r_timer - TIMER_W'(1);
            READY:  if (i_grant)  w_state_nxt = ISSUED;
            ISSUED: if (i_retire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_state = r_state;
    assign o_seq   = r_seq;
endmodule

// File: rtl/ooo_read_responder.sv
// Read target returning R beats out of order after an ID-dependent latency;
// rdata carries the request's arrival sequence number so ordering is observable.
module ooo_read_responder
    import rob_pkg::*;
#(
    parameter int         DATA_WIDTH      = 8,
    parameter int         MIN_LAT         = 2,
    parameter logic [2:0] LAT_XOR         = 3'd0,
    parameter int         MAX_OUTSTANDING = 16,
    parameter int         DATA_OFFSET     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i
);
    localparam int CNT_W = 5;

    slot_state_t           w_state [NUM_IDS];
    logic [DATA_WIDTH-1:0] w_seq   [NUM_IDS];
    logic [NUM_IDS-1:0]    w_load, w_grant, w_retire;
    logic [TIMER_W-1:0]    w_lat;
    logic                  w_ar_fire, w_r_fire, w_load_en, w_grant_vld;
    id_t                   w_grant_id;

    logic [DATA_WIDTH-1:0] r_seq_cnt;
    logic [CNT_W-1:0]      r_outst;
    id_t                   r_rr;
    logic                  r_rvalid;
    id_t                   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    assign s_arready_o = (w_state[s_arid_i] == IDLE) &&
                         (r_outst < CNT_W'(MAX_OUTSTANDING)) && rst_n;
    assign w_ar_fire   = s_arvalid_i && s_arready_o;
    assign w_r_fire    = r_rvalid && s_rready_i;
    assign w_load_en   = !r_rvalid || s_rready_i;
    assign w_lat       = TIMER_W'(MIN_LAT - 1) + TIMER_W'(s_arid_i[2:0] ^ LAT_XOR);

    // Round-robin: first READY slot strictly after the last granted ID.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = 1; k <= NUM_IDS; k++) begin
            if (!w_grant_vld && w_state[id_t'(r_rr + id_t'(k))] == READY) begin
                w_grant_vld = 1'b1;
                w_grant_id  = id_t'(r_rr + id_t'(k));
            end
        end
    end

    always_comb begin
        w_load   = '0;
        w_grant  = '0;
        w_retire = '0;
        w_load[s_arid_i]   = w_ar_fire;
        w_grant[w_grant_id] = w_grant_vld && w_load_en;
        w_retire[r_rid]    = w_r_fire;
    end

    for (genvar g = 0; g < NUM_IDS; g++) begin : g_slot
        ooo_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load[g]),
            .i_lat    (w_lat),
            .i_seq    (r_seq_cnt),
            .i_grant  (w_grant[g]),
            .i_retire (w_retire[g]),
            .o_state  (w_state[g]),
            .o_seq    (w_seq[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq_cnt <= '0;
            r_outst   <= '0;
            r_rr      <= id_t'(NUM_IDS - 1);
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_ar_fire)
                r_seq_cnt <= r_seq_cnt + DATA_WIDTH'(1);
            case ({w_ar_fire, w_r_fire})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
            // Reload in the retire cycle so back-to-back beats carry no bubble.
            if (w_load_en) begin
                r_rvalid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_rid   <= w_grant_id;
                    r_rdata <= w_seq[w_grant_id] + DATA_WIDTH'(DATA_OFFSET);
                    r_rr    <= w_grant_id;
                end
            end
        end
    end

    assign s_rvalid_o = r_rvalid;
    assign s_rid_o    = r_rid;
    assign s_rdata_o  = r_rdata;
endmodule
